// File: rtl/channel_err_inj_if.sv
// Symbol stream into and out of the channel error injector, plus its statistics.
// slave is the injector side; master is the encoder/decoder side.
interface channel_err_inj_if #(
  parameter int W      = 2,
  parameter int MAXB_W = 3,
  parameter int CT_W   = 16
);
  logic              valid_i;
  logic [W-1:0]      sym_i;
  logic [1:0]        mode_i;
  logic [MAXB_W-1:0] burst_len_i;
  logic              force_i;
  logic              valid_o;
  logic [W-1:0]      sym_o;
  logic [W-1:0]      err_o;
  logic              burst_o;
  logic [CT_W-1:0]   sym_ct_o;
  logic [CT_W-1:0]   bad_bit_ct_o;

  modport slave (
    input  valid_i, sym_i, mode_i, burst_len_i, force_i,
    output valid_o, sym_o, err_o, burst_o, sym_ct_o, bad_bit_ct_o
  );
  modport master (
    output valid_i, sym_i, mode_i, burst_len_i, force_i,
    input  valid_o, sym_o, err_o, burst_o, sym_ct_o, bad_bit_ct_o
  );
endinterface

// File: rtl/channel_err_inj.sv
// Channel error injector: XORs random single-bit errors or bursts into a coded
// symbol stream, one cycle latency, with saturating symbol/flipped-bit counters.
module channel_err_inj #(
  parameter int          W         = 2,
  parameter int          RATE_BITS = 5,
  parameter int          MAXB_W    = 3,
  parameter int          CT_W      = 16,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  channel_err_inj_if.slave bus
);
  localparam int PW = $clog2(W + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, nxt_state;
  logic [15:0]       lfsr, lfsr_nxt;
  logic [MAXB_W-1:0] rem, nxt_rem;
  logic [1:0]        lmode, nxt_lmode;
  logic [W-1:0]      mask, bit0, rnd_raw, rnd_mask, hit_mask;
  logic              trig;
  logic [PW-1:0]     pop;
  logic [CT_W:0]     bad_sum;

  assign trig     = &lfsr[RATE_BITS-1:0];
  assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  assign bit0     = W'(1);
  assign hit_mask = bit0 << (lfsr[15:8] % 8'(W));
  // An all-zero random mask would silently skip a burst symbol; fall back to bit 0.
  assign rnd_mask = (rnd_raw == '0) ? bit0 : rnd_raw;

  always_comb begin
    rnd_raw = '0;
    for (int i = 0; i < W && i < 16; i++) rnd_raw[i] = lfsr[i];
  end

  always_comb begin
    mask      = '0;
    nxt_state = state;
    nxt_rem   = rem;
    nxt_lmode = lmode;
    if (bus.valid_i) begin
      if (state == IDLE) begin
        if (bus.mode_i != 2'b00 && (trig || bus.force_i)) begin
          if (bus.mode_i == 2'b01) begin
            mask = hit_mask;
          end else begin
            mask      = (bus.mode_i == 2'b10) ? bit0 : rnd_mask;
            nxt_rem   = (bus.burst_len_i == '0) ? '0 : bus.burst_len_i - 1'b1;
            nxt_lmode = bus.mode_i;
            if (nxt_rem != '0) nxt_state = BURST;
          end
        end
      end else if (bus.mode_i == 2'b00) begin
        nxt_rem   = '0;
        nxt_state = IDLE;
      end else begin
        mask    = (lmode == 2'b10) ? bit0 : rnd_mask;
        nxt_rem = rem - 1'b1;
        if (rem == MAXB_W'(1)) nxt_state = IDLE;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) pop = pop + PW'(mask[i]);
  end

  assign bad_sum = {1'b0, bus.bad_bit_ct_o} + (CT_W+1)'(pop);
  assign bus.burst_o = (state == BURST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.valid_o      <= 1'b0;
      bus.sym_o        <= '0;
      bus.err_o        <= '0;
      bus.sym_ct_o     <= '0;
      bus.bad_bit_ct_o <= '0;
      lfsr             <= SEED;
      state            <= IDLE;
      rem              <= '0;
      lmode            <= 2'b00;
    end else begin
      bus.valid_o <= bus.valid_i;
      if (bus.valid_i) begin
        bus.sym_o        <= bus.sym_i ^ mask;
        bus.err_o        <= mask;
        lfsr             <= lfsr_nxt;
        state            <= nxt_state;
        rem              <= nxt_rem;
        lmode            <= nxt_lmode;
        if (bus.sym_ct_o != '1) bus.sym_ct_o <= bus.sym_ct_o + 1'b1;
        bus.bad_bit_ct_o <= bad_sum[CT_W] ? '1 : bad_sum[CT_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_channel_err_inj.sv
// Directed bench for channel_err_inj: stimulus pushes expected symbols into a
// scoreboard queue, a negedge monitor pops and compares every valid output.
module tb_channel_err_inj;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [1:0] sym = '0;
  logic [1:0] mode = '0;
  logic [2:0] blen = '0;
  logic       frc = 1'b0;

  typedef struct { logic [1:0] sym; logic [1:0] err; } exp_t;
  exp_t q[$];

  int ncmp = 0;
  int nfail = 0;
  int bcyc = 0;
  int exp_sym = 0;
  int exp_bad = 0;
  logic [15:0] mlfsr = 16'hACE1;

  always #5 clk = ~clk;

  channel_err_inj_if #(.W(2), .MAXB_W(3), .CT_W(16)) bi();
  channel_err_inj_if #(.W(2), .MAXB_W(3), .CT_W(4))  bs();

  assign bi.valid_i = valid;  assign bs.valid_i = valid;
  assign bi.sym_i = sym;      assign bs.sym_i = sym;
  assign bi.mode_i = mode;    assign bs.mode_i = mode;
  assign bi.burst_len_i = blen; assign bs.burst_len_i = blen;
  assign bi.force_i = frc;    assign bs.force_i = frc;

  channel_err_inj #(.W(2), .RATE_BITS(1), .MAXB_W(3), .CT_W(16), .SEED(16'hACE1))
    u_dut (.clk(clk), .rst(rst), .bus(bi.slave));
  channel_err_inj #(.W(2), .RATE_BITS(1), .MAXB_W(3), .CT_W(4), .SEED(16'hACE1))
    u_sat (.clk(clk), .rst(rst), .bus(bs.slave));

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  always @(negedge clk) begin
    if (bi.burst_o) bcyc++;
    if (bi.valid_o) begin
      ncmp++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL spurious_valid: got sym %b with no expected entry", bi.sym_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bi.sym_o !== e.sym || bi.err_o !== e.err) begin
          nfail++;
          $display("FAIL stream @%0t: got sym %b err %b expected sym %b err %b",
                   $time, bi.sym_o, bi.err_o, e.sym, e.err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] s, input logic [1:0] m, input logic [2:0] len,
                      input logic f, input logic [1:0] msk);
    valid = 1'b1; sym = s; mode = m; blen = len; frc = f;
    q.push_back('{s ^ msk, msk});
    exp_sym++;
    exp_bad += int'(msk[0]) + int'(msk[1]);
    mlfsr = lfsr_next(mlfsr);
    @(posedge clk); #1;
    valid = 1'b0; frc = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_ct(input string tag);
    chk({tag, "_sym_ct"}, 32'(bi.sym_ct_o), exp_sym);
    chk({tag, "_bad_ct"}, 32'(bi.bad_bit_ct_o), exp_bad);
    chk({tag, "_sat_sym_ct"}, 32'(bs.sym_ct_o), sat15(exp_sym));
    chk({tag, "_sat_bad_ct"}, 32'(bs.bad_bit_ct_o), sat15(exp_bad));
  endtask

  initial begin
    logic [1:0] m;
    logic       f;
    #1 rst = 1'b0;
    #2;
    chk("rst_valid", 32'(bi.valid_o), 0);
    chk("rst_sym",   32'(bi.sym_o), 0);
    chk("rst_err",   32'(bi.err_o), 0);
    chk("rst_burst", 32'(bi.burst_o), 0);
    chk_ct("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // clean pass-through
    for (int i = 0; i < 100; i++) send(2'b10, 2'b00, 3'd0, 1'b0, 2'b00);
    idle(2);
    chk_ct("clean");

    // forced fixed-bit burst of 4, then the stream is clean again
    bcyc = 0;
    send(2'b00, 2'b10, 3'd4, 1'b1, 2'b01);
    for (int i = 0; i < 3; i++) send(2'b00, 2'b10, 3'd4, 1'b0, 2'b01);
    send(2'b00, 2'b00, 3'd4, 1'b0, 2'b00);
    send(2'b00, 2'b00, 3'd4, 1'b0, 2'b00);
    idle(3);
    chk("burst4_cycles", bcyc, 3);
    chk_ct("burst4");

    // burst with a 2-cycle gap; mode/len/force changes mid-burst are ignored
    bcyc = 0;
    send(2'b11, 2'b10, 3'd4, 1'b1, 2'b01);
    send(2'b11, 2'b11, 3'd7, 1'b1, 2'b01);
    idle(2);
    send(2'b10, 2'b01, 3'd1, 1'b0, 2'b01);
    send(2'b10, 2'b11, 3'd7, 1'b0, 2'b01);
    send(2'b10, 2'b00, 3'd7, 1'b0, 2'b00);
    idle(3);
    chk("gap_cycles", bcyc, 5);
    chk_ct("gap");

    // random-mask burst aborted by mode 00 after the first symbol
    bcyc = 0;
    m = (mlfsr[1:0] == 2'b00) ? 2'b01 : mlfsr[1:0];
    send(2'b00, 2'b11, 3'd3, 1'b1, m);
    send(2'b01, 2'b00, 3'd3, 1'b0, 2'b00);
    chk("abort_burst_low", 32'(bi.burst_o), 0);
    send(2'b01, 2'b00, 3'd3, 1'b0, 2'b00);
    idle(3);
    chk("abort_cycles", bcyc, 1);
    chk_ct("abort");

    // single-bit random errors at rate 1/2; force with mode 00 must do nothing
    for (int i = 0; i < 1000; i++) begin
      f = (i % 7) == 0;
      if (i % 50 == 3) begin
        send(2'($urandom), 2'b00, 3'd0, 1'b1, 2'b00);
      end else begin
        m = (mlfsr[0] || f) ? (2'b01 << mlfsr[8]) : 2'b00;
        send(2'($urandom), 2'b01, 3'd0, f, m);
      end
    end
    idle(2);
    chk_ct("random");

    // reset mid-burst with saturated small counters, then a full-length burst
    send(2'b00, 2'b10, 3'd4, 1'b1, 2'b01);
    send(2'b00, 2'b10, 3'd4, 1'b0, 2'b01);
    chk("presat_sym_ct", 32'(bs.sym_ct_o), 15);
    chk("presat_bad_ct", 32'(bs.bad_bit_ct_o), 15);
    #6 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bi.valid_o), 0);
    chk("mid_rst_sym",   32'(bi.sym_o), 0);
    chk("mid_rst_err",   32'(bi.err_o), 0);
    chk("mid_rst_burst", 32'(bi.burst_o), 0);
    mlfsr = 16'hACE1; exp_sym = 0; exp_bad = 0;
    chk_ct("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    bcyc = 0;
    send(2'b00, 2'b10, 3'd4, 1'b1, 2'b01);
    for (int i = 0; i < 3; i++) send(2'b00, 2'b10, 3'd4, 1'b0, 2'b01);
    send(2'b00, 2'b00, 3'd0, 1'b0, 2'b00);
    idle(3);
    chk("post_rst_cycles", bcyc, 3);
    chk_ct("post_rst");

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
